coin_credit: RTL and testbench

COIN_CREDIT -- requirements
Module: coin_credit

---
 rtl/coin_credit.sv | 157 +++++++++++++++
 tb/tb_coin_credit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_credit.sv
// coin_credit: coin acceptor credit accumulator for a drink vending machine.
//   Three asynchronous coin-sensor levels are synchronized, edge-detected and
//   debounced by a per-input lockout. Accepted coins are summed into a
//   saturating credit register, and a COLLECT/ARMED/REFUND FSM hands off to
//   the dispense FSM (coin, vend_done) and the change hopper (refund_*).
// Ports:
//   clk, resetn                          clock, async active-low reset
//   nickel_raw, dime_raw, quarter_raw    async sensor levels (5/10/25)
//   cancel, vend_done, refund_ack        synchronous control pulses
//   coin                                 1-cycle pulse: credit reached PRICE
//   credit                               current credit
//   refund_valid, refund_amt             refund request and value
//   overflow                             1-cycle pulse: addition saturated
module coin_credit #(
  parameter int unsigned PRICE    = 50,
  parameter int unsigned CREDIT_W = 8,
  parameter int unsigned LOCKOUT  = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                nickel_raw,
  input  logic                dime_raw,
  input  logic                quarter_raw,
  input  logic                cancel,
  input  logic                vend_done,
  input  logic                refund_ack,
  output logic                coin,
  output logic [CREDIT_W-1:0] credit,
  output logic                refund_valid,
  output logic [CREDIT_W-1:0] refund_amt,
  output logic                overflow
);

  localparam int unsigned LW   = (LOCKOUT < 1) ? 1 : $clog2(LOCKOUT + 1);
  localparam logic [31:0] MAXC = (32'd1 << CREDIT_W) - 32'd1;

  typedef enum logic [1:0] {COLLECT, ARMED, REFUND} state_t;

  state_t        state;
  logic [2:0]    raw;
  logic [2:0]    sync1, sync2, prev;
  logic [1:0]    warm;
  logic [LW-1:0] lock_cnt [3];
  logic [2:0]    accept;
  logic [31:0]   add_val, raw_sum, sum, rem;
  logic          sat;
  logic [CREDIT_W-1:0] sum_c, rem_c;

  assign raw = {quarter_raw, dime_raw, nickel_raw};

  // Events are suppressed until prev has captured a settled synchronizer
  // output, so a level already high when reset is released is not an edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      warm  <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prev  <= sync2;
      if (warm != 2'd3) warm <= warm + 2'd1;
    end
  end

  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      accept[i] = sync2[i] && !prev[i] && (warm == 2'd3) && (lock_cnt[i] == '0);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < 3; i++) lock_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (accept[i])              lock_cnt[i] <= LW'(LOCKOUT);
        else if (lock_cnt[i] != '0) lock_cnt[i] <= lock_cnt[i] - 1'b1;
      end
    end
  end

  // Same-cycle coins form a single addition; sum is computed wide so that
  // saturation and the PRICE compare work even when PRICE exceeds MAXC.
  always_comb begin
    add_val = (accept[0] ? 32'd5 : 32'd0) + (accept[1] ? 32'd10 : 32'd0) +
              (accept[2] ? 32'd25 : 32'd0);
    raw_sum = {{(32-CREDIT_W){1'b0}}, credit} + add_val;
    sat     = raw_sum > MAXC;
    sum     = sat ? MAXC : raw_sum;
    rem     = sum - PRICE;
    sum_c   = sum[CREDIT_W-1:0];
    rem_c   = rem[CREDIT_W-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= COLLECT;
      credit       <= '0;
      coin         <= 1'b0;
      refund_valid <= 1'b0;
      refund_amt   <= '0;
      overflow     <= 1'b0;
    end else begin
      coin     <= 1'b0;
      overflow <= 1'b0;
      case (state)
        COLLECT: begin
          overflow <= sat;
          if (cancel && sum != 32'd0) begin
            state        <= REFUND;
            refund_valid <= 1'b1;
            refund_amt   <= sum_c;
            credit       <= '0;
          end else begin
            credit <= sum_c;
            if (sum >= PRICE) begin
              state <= ARMED;
              coin  <= 1'b1;
            end
          end
        end
        ARMED: begin
          overflow <= sat;
          if (vend_done) begin
            credit <= '0;
            if (rem != 32'd0) begin
              state        <= REFUND;
              refund_valid <= 1'b1;
              refund_amt   <= rem_c;
            end else begin
              state <= COLLECT;
            end
          end else if (cancel) begin
            state        <= REFUND;
            refund_valid <= 1'b1;
            refund_amt   <= sum_c;
            credit       <= '0;
          end else begin
            credit <= sum_c;
          end
        end
        REFUND: begin
          if (refund_ack) begin
            state        <= COLLECT;
            refund_valid <= 1'b0;
            refund_amt   <= '0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_coin_credit.sv
module tb_coin_credit;
  logic       clk = 1'b0;
  logic       resetn, resetn2;
  logic       nickel_raw, dime_raw, quarter_raw, cancel, vend_done, refund_ack;
  logic       coin, refund_valid, overflow;
  logic [7:0] credit, refund_amt;
  logic       q2, cancel2, ack2, zero2;
  logic       coin2, refund_valid2, overflow2;
  logic [5:0] credit2, refund_amt2;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  coin_credit dut (
    .clk(clk), .resetn(resetn),
    .nickel_raw(nickel_raw), .dime_raw(dime_raw), .quarter_raw(quarter_raw),
    .cancel(cancel), .vend_done(vend_done), .refund_ack(refund_ack),
    .coin(coin), .credit(credit), .refund_valid(refund_valid),
    .refund_amt(refund_amt), .overflow(overflow)
  );

  coin_credit #(.PRICE(100), .CREDIT_W(6), .LOCKOUT(4)) dut2 (
    .clk(clk), .resetn(resetn2),
    .nickel_raw(zero2), .dime_raw(zero2), .quarter_raw(q2),
    .cancel(cancel2), .vend_done(zero2), .refund_ack(ack2),
    .coin(coin2), .credit(credit2), .refund_valid(refund_valid2),
    .refund_amt(refund_amt2), .overflow(overflow2)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // Raise the selected sensors for one cycle; returns on the negedge at which
  // the resulting credit update is first visible.
  task automatic pulse(input logic n, input logic d, input logic q);
    nickel_raw = n; dime_raw = d; quarter_raw = q;
    tick();
    nickel_raw = 0; dime_raw = 0; quarter_raw = 0;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    resetn = 0; resetn2 = 0;
    nickel_raw = 0; dime_raw = 0; quarter_raw = 1;
    cancel = 0; vend_done = 0; refund_ack = 0;
    q2 = 0; cancel2 = 0; ack2 = 0; zero2 = 0;
    repeat (2) tick();
    total++;
    if ({coin, refund_valid, overflow} !== 3'b000 || credit !== 8'd0 || refund_amt !== 8'd0) begin
      bad++;
      $display("FAIL reset_outputs got coin=%b rv=%b ovf=%b credit=%0d amt=%0d exp all 0",
               coin, refund_valid, overflow, credit, refund_amt);
    end
    resetn = 1; resetn2 = 1;
    repeat (6) tick();
    total++;
    if (credit !== 8'd0) begin
      bad++;
      $display("FAIL reset_high_level credit got=%0d exp=0", credit);
    end
    quarter_raw = 0;
    repeat (8) tick();
  endtask

  task automatic test_two_quarters();
    pulse(0, 0, 1);
    total++;
    if (credit !== 8'd25 || coin !== 1'b0) begin
      bad++;
      $display("FAIL q1 credit got=%0d exp=25 coin got=%b exp=0", credit, coin);
    end
    repeat (8) tick();
    pulse(0, 0, 1);
    total++;
    if (credit !== 8'd50 || coin !== 1'b1) begin
      bad++;
      $display("FAIL q2 credit got=%0d exp=50 coin got=%b exp=1", credit, coin);
    end
    tick();
    total++;
    if (credit !== 8'd50 || coin !== 1'b0) begin
      bad++;
      $display("FAIL q2_coin_once credit got=%0d exp=50 coin got=%b exp=0", credit, coin);
    end
    vend_done = 1; cancel = 1;
    tick();
    vend_done = 0; cancel = 0;
    total++;
    if (credit !== 8'd0 || refund_valid !== 1'b0 || refund_amt !== 8'd0) begin
      bad++;
      $display("FAIL vend_cancel credit got=%0d exp=0 rv got=%b exp=0 amt got=%0d exp=0",
               credit, refund_valid, refund_amt);
    end
    cancel = 1;
    tick();
    cancel = 0;
    total++;
    if (refund_valid !== 1'b0) begin
      bad++;
      $display("FAIL cancel_zero rv got=%b exp=0", refund_valid);
    end
  endtask

  task automatic test_dime_quarter();
    repeat (8) tick();
    pulse(0, 1, 1);
    total++;
    if (credit !== 8'd35 || coin !== 1'b0) begin
      bad++;
      $display("FAIL dq credit got=%0d exp=35 coin got=%b exp=0", credit, coin);
    end
    repeat (8) tick();
    pulse(0, 0, 1);
    total++;
    if (credit !== 8'd60 || coin !== 1'b1) begin
      bad++;
      $display("FAIL dq_q credit got=%0d exp=60 coin got=%b exp=1", credit, coin);
    end
    tick();
    total++;
    if (coin !== 1'b0) begin
      bad++;
      $display("FAIL dq_coin_once coin got=%b exp=0", coin);
    end
    vend_done = 1;
    tick();
    vend_done = 0;
    total++;
    if (refund_valid !== 1'b1 || refund_amt !== 8'd10 || credit !== 8'd0) begin
      bad++;
      $display("FAIL vend_change rv got=%b exp=1 amt got=%0d exp=10 credit got=%0d exp=0",
               refund_valid, refund_amt, credit);
    end
    refund_ack = 1;
    tick();
    refund_ack = 0;
    total++;
    if (refund_valid !== 1'b0 || refund_amt !== 8'd0 || credit !== 8'd0) begin
      bad++;
      $display("FAIL change_ack rv got=%b exp=0 amt got=%0d exp=0 credit got=%0d exp=0",
               refund_valid, refund_amt, credit);
    end
  endtask

  task automatic test_nickel_lockout();
    repeat (8) tick();
    // Rising edges two cycles apart: with a 4-cycle lockout only the 1st and
    // 4th of six are accepted.
    for (int i = 0; i < 6; i++) begin
      nickel_raw = 1; tick();
      nickel_raw = 0; tick();
    end
    repeat (3) tick();
    total++;
    if (credit !== 8'd10) begin
      bad++;
      $display("FAIL nickel_lockout credit got=%0d exp=10", credit);
    end
    cancel = 1; tick(); cancel = 0;
    total++;
    if (refund_valid !== 1'b1 || refund_amt !== 8'd10) begin
      bad++;
      $display("FAIL nickel_refund rv got=%b exp=1 amt got=%0d exp=10", refund_valid, refund_amt);
    end
    refund_ack = 1; tick(); refund_ack = 0;
    total++;
    if (refund_valid !== 1'b0) begin
      bad++;
      $display("FAIL nickel_ack rv got=%b exp=0", refund_valid);
    end
  endtask

  task automatic test_cancel_refund();
    repeat (8) tick();
    pulse(0, 0, 1);
    repeat (8) tick();
    pulse(1, 0, 0);
    total++;
    if (credit !== 8'd30) begin
      bad++;
      $display("FAIL cr_credit got=%0d exp=30", credit);
    end
    vend_done = 1; tick(); vend_done = 0;
    total++;
    if (credit !== 8'd30 || refund_valid !== 1'b0) begin
      bad++;
      $display("FAIL vend_in_collect credit got=%0d exp=30 rv got=%b exp=0", credit, refund_valid);
    end
    cancel = 1; tick(); cancel = 0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (refund_valid !== 1'b1 || refund_amt !== 8'd30 || credit !== 8'd0) begin
        bad++;
        $display("FAIL refund_hold[%0d] rv got=%b exp=1 amt got=%0d exp=30 credit got=%0d exp=0",
                 i, refund_valid, refund_amt, credit);
      end
      if (i == 0) quarter_raw = 1;
      if (i == 1) quarter_raw = 0;
      tick();
    end
    refund_ack = 1; tick(); refund_ack = 0;
    total++;
    if (refund_valid !== 1'b0 || refund_amt !== 8'd0 || credit !== 8'd0) begin
      bad++;
      $display("FAIL refund_ack rv got=%b exp=0 amt got=%0d exp=0 credit got=%0d exp=0",
               refund_valid, refund_amt, credit);
    end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 2; k++) begin
      q2 = 1; tick(); q2 = 0; repeat (2) tick();
      repeat (8) tick();
    end
    total++;
    if (credit2 !== 6'd50) begin
      bad++;
      $display("FAIL sat_pre credit got=%0d exp=50", credit2);
    end
    q2 = 1; tick(); q2 = 0; repeat (2) tick();
    total++;
    if (credit2 !== 6'd63 || overflow2 !== 1'b1) begin
      bad++;
      $display("FAIL sat credit got=%0d exp=63 ovf got=%b exp=1", credit2, overflow2);
    end
    tick();
    total++;
    if (credit2 !== 6'd63 || overflow2 !== 1'b0 || coin2 !== 1'b0) begin
      bad++;
      $display("FAIL sat_after credit got=%0d exp=63 ovf got=%b exp=0 coin got=%b exp=0",
               credit2, overflow2, coin2);
    end
    cancel2 = 1; tick(); cancel2 = 0;
    total++;
    if (refund_valid2 !== 1'b1 || refund_amt2 !== 6'd63) begin
      bad++;
      $display("FAIL sat_refund rv got=%b exp=1 amt got=%0d exp=63", refund_valid2, refund_amt2);
    end
    tick();
    #2 resetn2 = 0;
    #1;
    total++;
    if ({coin2, refund_valid2, overflow2} !== 3'b000 || credit2 !== 6'd0 || refund_amt2 !== 6'd0) begin
      bad++;
      $display("FAIL async_reset coin=%b rv=%b ovf=%b credit=%0d amt=%0d exp all 0",
               coin2, refund_valid2, overflow2, credit2, refund_amt2);
    end
    tick();
    resetn2 = 1;
    repeat (4) tick();
    total++;
    if (refund_valid2 !== 1'b0 || credit2 !== 6'd0) begin
      bad++;
      $display("FAIL post_reset rv got=%b exp=0 credit got=%0d exp=0", refund_valid2, credit2);
    end
  endtask

  initial begin
    test_reset();
    test_two_quarters();
    test_dime_quarter();
    test_nickel_lockout();
    test_cancel_refund();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
